mdu_iter: RTL and testbench



---
 rtl/mdu_iter_pkg.sv | 27 ++
 rtl/mdu_iter_div_step.sv | 22 ++
 rtl/mdu_iter.sv | 185 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// XLEN follows the core's immediate/datapath width.
package mdu_iter_pkg;

    localparam int ImmWidth   = 64;
    localparam int XLEN       = ImmWidth;
    localparam int MduOpWidth = 3;
    localparam int CntWidth   = 7;

    typedef enum logic [MduOpWidth-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module mdu_div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    assign shifted = {rem, in_bit};
    // The difference is below the divisor whenever it is kept, so W bits suffice.
    assign diff     = shifted[W-1:0] - divisor;
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff : shifted[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M unit: shift-add multiplier and restoring divider on
// operand magnitudes, with sign fix-up and W-op sign extension at the end.
module mdu_iter #(
    parameter int XLEN  = mdu_iter_pkg::XLEN,
    parameter int CNT_W = mdu_iter_pkg::CntWidth
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    localparam int HALF = XLEN / 2;
    localparam int DW   = 2 * XLEN;

    mdu_iter_pkg::mdu_state_e state_q, state_d;

    logic [2:0]       op_q;
    logic             word_q;
    logic             neg1_q, neg2_q;
    logic [DW-1:0]    acc_q;
    logic [DW-1:0]    mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  resp_data_q;

    logic accept, step, last;

    function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
        fix_word = w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Request decode, operand extension and special-case detection.
    logic            sgn1, sgn2, is_div, rem_op;
    logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_val, spec_res;
    logic            neg1, neg2, div_zero, div_ovf, special;

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (mdu_iter_pkg::mdu_op_e'(req_op))
            mdu_iter_pkg::MDU_MUL,
            mdu_iter_pkg::MDU_MULH,
            mdu_iter_pkg::MDU_DIV,
            mdu_iter_pkg::MDU_REM:    begin sgn1 = 1'b1; sgn2 = 1'b1; end
            mdu_iter_pkg::MDU_MULHSU: begin sgn1 = 1'b1; sgn2 = 1'b0; end
            default:                  begin sgn1 = 1'b0; sgn2 = 1'b0; end
        endcase
    end

    assign is_div = req_op[2];
    assign rem_op = req_op[1];
    assign ext1 = req_word ? {{HALF{sgn1 & req_src1[HALF-1]}}, req_src1[HALF-1:0]} : req_src1;
    assign ext2 = req_word ? {{HALF{sgn2 & req_src2[HALF-1]}}, req_src2[HALF-1:0]} : req_src2;
    assign neg1 = sgn1 & ext1[XLEN-1];
    assign neg2 = sgn2 & ext2[XLEN-1];
    assign mag1 = neg1 ? -ext1 : ext1;
    assign mag2 = neg2 ? -ext2 : ext2;

    assign min_val  = req_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                               : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (ext2 == '0);
    assign div_ovf  = sgn1 && (ext1 == min_val) && (&ext2);
    assign special  = is_div && (div_zero || div_ovf);

    always_comb begin
        if (div_zero) spec_res = rem_op ? ext1 : {XLEN{1'b1}};
        else          spec_res = rem_op ? {XLEN{1'b0}} : ext1;
        spec_res = fix_word(req_word, spec_res);
    end

    // One iteration: acc holds the product, or {remainder, dividend/quotient}.
    logic [XLEN-1:0] div_rem;
    logic            div_q;
    logic [DW-1:0]   acc_step, prod;
    logic [XLEN-1:0] quo, rmd, raw_res, final_res;

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem      (acc_q[DW-1:XLEN]),
        .in_bit   (acc_q[XLEN-1]),
        .divisor  (mplier_q),
        .rem_next (div_rem),
        .q_bit    (div_q)
    );

    always_comb begin
        if (op_q[2]) acc_step = {div_rem, acc_q[XLEN-2:0], div_q};
        else         acc_step = acc_q + (mplier_q[0] ? mcand_q : {DW{1'b0}});
        prod = (neg1_q ^ neg2_q) ? -acc_step : acc_step;
        quo  = (neg1_q ^ neg2_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rmd  = neg1_q ? -acc_step[DW-1:XLEN] : acc_step[DW-1:XLEN];
        case (mdu_iter_pkg::mdu_op_e'(op_q))
            mdu_iter_pkg::MDU_MUL:                       raw_res = prod[XLEN-1:0];
            mdu_iter_pkg::MDU_DIV, mdu_iter_pkg::MDU_DIVU: raw_res = quo;
            mdu_iter_pkg::MDU_REM, mdu_iter_pkg::MDU_REMU: raw_res = rmd;
            default:                                     raw_res = prod[DW-1:XLEN];
        endcase
        final_res = fix_word(word_q, raw_res);
    end

    // Control FSM; flush wins over both handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= mdu_iter_pkg::ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            mdu_iter_pkg::ST_IDLE: begin
                if (!flush && req_valid) begin
                    accept  = 1'b1;
                    state_d = special ? mdu_iter_pkg::ST_DONE : mdu_iter_pkg::ST_BUSY;
                end
            end
            mdu_iter_pkg::ST_BUSY: begin
                if (flush) begin
                    state_d = mdu_iter_pkg::ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == '0) begin
                        last    = 1'b1;
                        state_d = mdu_iter_pkg::ST_DONE;
                    end
                end
            end
            mdu_iter_pkg::ST_DONE: begin
                if (flush || resp_ready) state_d = mdu_iter_pkg::ST_IDLE;
            end
            default: state_d = mdu_iter_pkg::ST_IDLE;
        endcase
    end

    assign req_ready  = (state_q == mdu_iter_pkg::ST_IDLE);
    assign resp_valid = (state_q == mdu_iter_pkg::ST_DONE);
    assign resp_data  = resp_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            word_q      <= 1'b0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else if (accept) begin
            op_q     <= req_op;
            word_q   <= req_word;
            neg1_q   <= neg1;
            neg2_q   <= neg2;
            mplier_q <= mag2;
            cnt_q    <= req_word ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
            if (is_div) begin
                // W-op dividends start in the upper half so only HALF steps are needed.
                acc_q   <= {{XLEN{1'b0}}, (req_word ? {mag1[HALF-1:0], {HALF{1'b0}}} : mag1)};
                mcand_q <= '0;
            end else begin
                acc_q   <= '0;
                mcand_q <= {{XLEN{1'b0}}, mag1};
            end
            if (special) resp_data_q <= spec_res;
        end else if (step) begin
            acc_q   <= acc_step;
            mcand_q <= mcand_q << 1;
            if (!op_q[2]) mplier_q <= mplier_q >> 1;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (last) resp_data_q <= final_res;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: arithmetic results, latency,
// special divide cases, W-ops, backpressure, flush and mid-operation reset.
module tb_mdu_iter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic            req_word;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string           name;
        logic [2:0]      op;
        logic            word;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic w, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, output bit ok, output int waits);
        req_op = op; req_word = w; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 100) begin
            step();
            waits++;
        end
        ok = req_ready;
        if (ok) step();
        req_valid = 1'b0;
    endtask

    task automatic await_resp(output logic [XLEN-1:0] data, output int lat, output bit ok);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            step();
            lat++;
        end
        ok   = resp_valid;
        data = resp_data;
    endtask

    task automatic run_op(input logic [2:0] op, input logic w, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic [XLEN-1:0] data,
                          output int lat, output bit ok);
        int waits;
        issue(op, w, a, b, ok, waits);
        data = '0;
        lat  = 0;
        if (ok) await_resp(data, lat, ok);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++;
        if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_table(input vec_t v);
        logic [XLEN-1:0] data;
        int lat;
        bit ok;
        run_op(v.op, v.word, v.a, v.b, data, lat, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got no response want resp_valid", v.name);
        end else begin
            if (data !== v.exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", v.name, data, v.exp); end
            n_cmp++;
            if (lat !== v.lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", v.name, lat, v.lat); end
        end
        step();
    endtask

    task automatic test_mul();
        vec_t v[4];
        v[0] = '{"mul_7_m3",    3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        v[1] = '{"mulhu_ones",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        v[2] = '{"mulh_min2",   3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h4000_0000_0000_0000, 65};
        v[3] = '{"mulhsu_m1_2", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_div();
        vec_t v[4];
        v[0] = '{"div_m7_2",    3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        v[1] = '{"rem_m7_2",    3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        v[2] = '{"divu_100_7",  3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        v[3] = '{"remu_100_7",  3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_special();
        vec_t v[5];
        v[0] = '{"div_by_zero",  3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        v[1] = '{"rem_by_zero",  3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        v[2] = '{"divu_by_zero", 3'd5, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        v[3] = '{"div_ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        v[4] = '{"rem_ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
        for (int i = 0; i < 5; i++) run_table(v[i]);
    endtask

    task automatic test_word();
        vec_t v[4];
        v[0] = '{"divw_min_1",   3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
        v[1] = '{"mulw_7fff_2",  3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        v[2] = '{"divw_ovf",     3'd4, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 1};
        v[3] = '{"remuw_by_zero",3'd7, 1'b1, 64'hABCD_0000_FFFF_FFF0, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFF0, 1};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] data;
        int lat;
        bit ok;
        int bad;
        resp_ready = 1'b0;
        run_op(3'd0, 1'b0, 64'd6, 64'd7, data, lat, ok);
        n_cmp++;
        if (!ok || data !== 64'd42) begin
            n_fail++; $display("FAIL bp_first_result: got %h want %h", data, 64'd42);
        end
        // A competing request is presented while the response is held.
        req_op = 3'd5; req_word = 1'b0; req_src1 = 64'd100; req_src2 = 64'd7; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== 64'd42) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        resp_ready = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
        end
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got req_ready=%b want 0", req_ready);
        end
        await_resp(data, lat, ok);
        n_cmp++;
        if (!ok || data !== 64'd14 || lat !== 65) begin
            n_fail++; $display("FAIL b2b_result: got %h lat %0d want %h lat 65", data, lat, 64'd14);
        end
        step();
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] data;
        int lat;
        int waits;
        bit ok;
        int bad;
        // flush in IDLE swallows a same-cycle request
        req_op = 3'd5; req_word = 1'b0; req_src1 = 64'd1000; req_src2 = 64'd10;
        req_valid = 1'b1; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
        end
        // flush at BUSY cycle 20
        issue(3'd5, 1'b0, 64'd1000, 64'd10, ok, waits);
        for (int i = 0; i < 19; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy: got ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
        end
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (resp_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL flush_no_resp: got %0d valid cycles want 0", bad); end
        run_op(3'd7, 1'b0, 64'd1000, 64'd7, data, lat, ok);
        n_cmp++;
        if (!ok || data !== 64'd6) begin n_fail++; $display("FAIL flush_next: got %h want %h", data, 64'd6); end
        step();
        // flush in DONE drops the held response
        resp_ready = 1'b0;
        run_op(3'd5, 1'b0, 64'd50, 64'd5, data, lat, ok);
        flush = 1'b1;
        step();
        flush = 1'b0;
        resp_ready = 1'b1;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_done: got valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_busy();
        logic [XLEN-1:0] data;
        int lat;
        int waits;
        bit ok;
        issue(3'd0, 1'b0, 64'd123, 64'd456, ok, waits);
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_busy: got ready=%b valid=%b data=%h want ready=1 valid=0 data=0",
                     req_ready, resp_valid, resp_data);
        end
        rst_n = 1'b1;
        step();
        run_op(3'd0, 1'b0, 64'd123, 64'd456, data, lat, ok);
        n_cmp++;
        if (!ok || data !== 64'd56088) begin
            n_fail++; $display("FAIL reset_next: got %h want %h", data, 64'd56088);
        end
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_word   = 1'b0;
        req_src1   = '0;
        req_src2   = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
